// File: rtl/mul16_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul16_seq_if
//  Description : Request/response bundle for the sequential 16x16 multiplier.
//                master : drives start/a/b, observes busy/done/out
//                slave  : the multiplier itself
//  Signals     : start      - operation request
//                a, b       - multiplicand / multiplier
//                busy       - operation in progress (RUN or DONE)
//                done       - one-cycle completion pulse
//                out        - low 16 bits of a*b
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul16_seq_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] out;

  modport master (
    output start, a, b,
    input  busy, done, out
  );

  modport slave (
    input  start, a, b,
    output busy, done, out
  );
endinterface
`default_nettype wire

// File: rtl/mul16_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mul16_seq
//  Description : Shift-and-add 16x16 multiplier returning the low 16 bits of
//                the product. All accumulation goes through a single add16
//                instance; carry-out is discarded so the result wraps.
//  Ports       : clk     - clock, rising-edge active
//                reset   - asynchronous, active-high reset
//                bus     - mul16_seq_if.slave (start, a, b, busy, done, out)
//  Parameters  : EARLY_EXIT - nonzero: stop once remaining multiplier bits
//                             are all zero; zero: always 16 RUN cycles
//  Revision    : 1.0 - initial release
// ============================================================================

// Plain 16-bit adder; the carry-out is intentionally dropped.
module add16 (
  input  wire logic [15:0] x,
  input  wire logic [15:0] y,
  output logic      [15:0] sum
);
  assign sum = x + y;
endmodule

module mul16_seq #(
  parameter int EARLY_EXIT = 1
) (
  input  wire logic     clk,
  input  wire logic     reset,
  mul16_seq_if.slave    bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [15:0] acc;
  logic [3:0]  cnt;
  logic [15:0] acc_sum;
  logic        run_last;

  add16 u_add16 (
    .x   (acc),
    .y   (mcand),
    .sum (acc_sum)
  );

  // The current cycle is the final RUN cycle either after the 16th bit, or
  // (with early exit) when nothing but zeros would be left after this shift.
  assign run_last = (cnt == 4'd15) ||
                    ((EARLY_EXIT != 0) && (mplier[15:1] == 15'd0));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (run_last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      RUN:  bus.busy = 1'b1;
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath. Operands are captured only on an accepted start, so input
  // changes mid-operation are invisible; acc is held through DONE and IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= 16'd0;
      mplier <= 16'd0;
      acc    <= 16'd0;
      cnt    <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= bus.a;
            mplier <= bus.b;
            acc    <= 16'd0;
            cnt    <= 4'd0;
          end
        end
        RUN: begin
          if (mplier[0]) begin
            acc <= acc_sum;
          end
          mcand  <= {mcand[14:0], 1'b0};
          mplier <= {1'b0, mplier[15:1]};
          cnt    <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.out = acc;

endmodule
`default_nettype wire

// File: tb/tb_mul16_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul16_seq
//  Description : Directed self-checking bench for mul16_seq. Two instances
//                are built, one with EARLY_EXIT=1 and one with EARLY_EXIT=0;
//                sel picks which one an operation is sent to.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul16_seq;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic sel;            // 0: early-exit instance, 1: full-length instance

  mul16_seq_if if1 ();
  mul16_seq_if if0 ();

  mul16_seq #(.EARLY_EXIT(1)) dut_ee (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  mul16_seq #(.EARLY_EXIT(0)) dut_full (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        m_busy;
  logic        m_done;
  logic [15:0] m_out;

  always_comb begin
    m_busy = sel ? if0.busy : if1.busy;
    m_done = sel ? if0.done : if1.done;
    m_out  = sel ? if0.out  : if1.out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [15:0] av, input logic [15:0] bv);
    if1.start = 1'b0;
    if0.start = 1'b0;
    if (sel) begin
      if0.start = st; if0.a = av; if0.b = bv;
    end else begin
      if1.start = st; if1.a = av; if1.b = bv;
    end
  endtask

  // Launches one operation and follows it to completion. Sample index n=1 is
  // the first sample after the accepting edge, so done is expected at n=k+1
  // and busy is expected high for exactly k+1 samples. Extra start pulses
  // (operands 1*1) are injected before the edges following samples p1 and p2.
  task automatic op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                    input int exp_n, input logic [15:0] exp_out,
                    input int p1, input int p2);
    int n;
    int busy_cnt;
    int done_cnt;
    int done_at;
    @(negedge clk);
    drive(1'b1, av, bv);
    @(posedge clk);
    #1;
    // Scramble operands right after acceptance; the result must not care.
    drive(1'b0, ~av, bv ^ 16'h5A5A);
    n = 1; busy_cnt = 0; done_cnt = 0; done_at = -1;
    check({tag, " busy_after_accept"}, {31'd0, m_busy}, 32'd1);
    while (n < 40) begin
      if (m_busy) busy_cnt++;
      if (m_done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (!m_busy) break;
      if (n == p1 || n == p2) drive(1'b1, 16'h0001, 16'h0001);
      else                    drive(1'b0, 16'h0001, 16'h0001);
      @(posedge clk);
      #1;
      n++;
    end
    drive(1'b0, 16'h0000, 16'h0000);
    check({tag, " timeout"},    {31'd0, (n >= 40)}, 32'd0);
    check({tag, " done_cycle"}, done_at,  exp_n);
    check({tag, " done_count"}, done_cnt, 32'd1);
    check({tag, " busy_count"}, busy_cnt, exp_n);
    check({tag, " out"},        {16'd0, m_out}, {16'd0, exp_out});
    repeat (3) @(posedge clk);
    #1;
    check({tag, " out_hold"},   {16'd0, m_out}, {16'd0, exp_out});
    check({tag, " idle_busy"},  {31'd0, m_busy}, 32'd0);
  endtask

  initial begin
    int seen_done;
    checks = 0;
    errors = 0;
    sel    = 1'b0;
    reset  = 1'b1;
    if1.start = 1'b0; if1.a = 16'd0; if1.b = 16'd0;
    if0.start = 1'b0; if0.a = 16'd0; if0.b = 16'd0;

    // Reset values hold before any clock edge has occurred.
    #2;
    check("rst busy_ee",   {31'd0, if1.busy}, 32'd0);
    check("rst done_ee",   {31'd0, if1.done}, 32'd0);
    check("rst out_ee",    {16'd0, if1.out},  32'd0);
    check("rst busy_full", {31'd0, if0.busy}, 32'd0);
    check("rst out_full",  {16'd0, if0.out},  32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Early-exit instance
    sel = 1'b0;
    op("ee_3x5",      16'h0003, 16'h0005,  4, 16'h000F, -1, -1);
    op("ee_ffff_sq",  16'hFFFF, 16'hFFFF, 17, 16'h0001, -1, -1);
    op("ee_b_zero",   16'h1234, 16'h0000,  2, 16'h0000, -1, -1);
    op("ee_ff_x_101", 16'h00FF, 16'h0101, 10, 16'hFFFF, -1, -1);
    op("ee_wrap",     16'h8000, 16'h0002,  3, 16'h0000, -1, -1);
    // b=0x0010 has bit length 5: RUN samples 1..5, DONE at sample 6.
    // Pulse start during RUN (sample 2) and during DONE (sample 6).
    op("ee_ignore",   16'h0010, 16'h0010,  6, 16'h0100,  2,  6);

    // Full-length instance
    sel = 1'b1;
    op("full_3x5",    16'h0003, 16'h0005, 17, 16'h000F, -1, -1);
    op("full_b_zero", 16'h1234, 16'h0000, 17, 16'h0000, -1, -1);

    // Asynchronous reset in the 5th RUN cycle of 0xFFFF*0xFFFF.
    sel = 1'b0;
    @(negedge clk);
    drive(1'b1, 16'hFFFF, 16'hFFFF);
    @(posedge clk);
    #1;
    drive(1'b0, 16'hFFFF, 16'hFFFF);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("abort busy_before", {31'd0, m_busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort busy_now", {31'd0, m_busy}, 32'd0);
    check("abort out_now",  {16'd0, m_out},  32'd0);
    check("abort done_now", {31'd0, m_done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (m_done || m_busy) seen_done++;
    end
    check("abort no_done", seen_done, 32'd0);
    op("after_rst_2x3", 16'h0002, 16'h0003, 3, 16'h0006, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
